// File: rtl/systolic_pkg.sv
// Shared defaults, FSM encoding and index-width helpers
// for the systolic array feeder.
package systolic_pkg;

  localparam int DW_DEF = 32;
  localparam int N_DEF  = 3;
  localparam int M_DEF  = 3;
  localparam int K_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One skewed lane: registers element (beat - OFF) of its K-entry
// slice while that index is in range, else drives zero.
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int K          = K_DEF,
  parameter int OFF        = 0,
  parameter int TW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  load,
  input  logic [TW-1:0]         beat,
  input  logic [DATA_WIDTH-1:0] elems [K],
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);

  localparam int KW = idx_w(K);

  int            d;
  logic [KW-1:0] k_idx;
  logic          in_rng;

  always_comb begin
    d      = int'(beat) - OFF;
    k_idx  = d[KW-1:0];
    in_rng = load && (d >= 0) && (d < K);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      valid <= in_rng;
      data  <= in_rng ? elems[k_idx] : '0;
    end
  end

endmodule

// File: rtl/matrix_skew_feeder.sv
// Buffers an A (NxK) and B (KxM) tile and streams them diagonally
// skewed into a systolic array. Optional stall: FEEDER_STALL_EN.
module matrix_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int K          = K_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [idx_w(max2(N,K))-1:0]  wr_row,
  input  logic [idx_w(max2(M,K))-1:0]  wr_col,
  input  logic [DATA_WIDTH-1:0]        wr_data,
`ifdef FEEDER_STALL_EN
  input  logic                         stall,
`endif
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [N*DATA_WIDTH-1:0]      a_data,
  output logic [N-1:0]                 a_valid,
  output logic [M*DATA_WIDTH-1:0]      b_data,
  output logic [M-1:0]                 b_valid
);

  localparam int T  = K + max2(N, M) - 1;
  // FLUSH plus the DONE cycle together give the N+M-1 drain window
  localparam int FL = N + M - 2;
  localparam int TW = idx_w(T);
  localparam int FW = idx_w((FL > 0) ? FL : 1);

`ifndef FEEDER_STALL_EN
  logic stall;
  assign stall = 1'b0;
`endif

  state_t        state, state_n;
  logic [TW-1:0] t, t_n;
  logic [FW-1:0] f, f_n;
  logic          hold, load;
  logic          wr_a, wr_b;

  logic [DATA_WIDTH-1:0] a_mem  [N][K];
  logic [DATA_WIDTH-1:0] b_mem  [M][K];
  logic [DATA_WIDTH-1:0] a_view [N][K];
  logic [DATA_WIDTH-1:0] b_view [M][K];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    wr_a = wr_en && !wr_sel && (state == IDLE) &&
           (int'(wr_row) < N) && (int'(wr_col) < K);
    wr_b = wr_en && wr_sel && (state == IDLE) &&
           (int'(wr_row) < K) && (int'(wr_col) < M);
  end

  always_ff @(posedge clk) begin
    if (wr_a) a_mem[wr_row][wr_col] <= wr_data;
    if (wr_b) b_mem[wr_col][wr_row] <= wr_data;
  end

  // Lanes load beat 0 on the start edge, so they see a same-cycle write
  always_comb begin
    a_view = a_mem;
    b_view = b_mem;
    if (wr_a) a_view[wr_row][wr_col] = wr_data;
    if (wr_b) b_view[wr_col][wr_row] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      f     <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
      f     <= f_n;
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    f_n     = f;
    hold    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = FEED;
          t_n     = '0;
        end
      end
      FEED: begin
        if (stall) begin
          hold = 1'b1;
        end else if (int'(t) == T - 1) begin
          state_n = (FL > 0) ? FLUSH : DONE;
          t_n     = '0;
          f_n     = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      FLUSH: begin
        if (stall) begin
          hold = 1'b1;
        end else if (int'(f) == FL - 1) begin
          state_n = DONE;
          f_n     = '0;
        end else begin
          f_n = f + 1'b1;
        end
      end
      DONE: state_n = IDLE;
    endcase
    load = (state_n == FEED);
  end

  for (genvar i = 0; i < N; i++) begin : g_a
    feeder_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .K          (K),
      .OFF        (i),
      .TW         (TW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .hold  (hold),
      .load  (load),
      .beat  (t_n),
      .elems (a_view[i]),
      .data  (a_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid (a_valid[i])
    );
  end

  for (genvar j = 0; j < M; j++) begin : g_b
    feeder_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .K          (K),
      .OFF        (j),
      .TW         (TW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .hold  (hold),
      .load  (load),
      .beat  (t_n),
      .elems (b_view[j]),
      .data  (b_data[j*DATA_WIDTH +: DATA_WIDTH]),
      .valid (b_valid[j])
    );
  end

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Randomized bench for matrix_skew_feeder against a phase-based
// reference model of the skewed operand stream.
module tb_matrix_skew_feeder;

  localparam int DW   = 32;
  localparam int N    = 3;
  localparam int M    = 3;
  localparam int K    = 3;
  localparam int T    = K + 3 - 1;
  localparam int LAST = T + N + M - 2;
`ifdef FEEDER_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_sel, start, stall;
  logic [1:0]    wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic          busy, done;
  logic [N*DW-1:0] a_data;
  logic [M*DW-1:0] b_data;
  logic [N-1:0]  a_valid;
  logic [M-1:0]  b_valid;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ma [N][K];
  logic [31:0] mb [K][M];

  always #5 clk = ~clk;

  matrix_skew_feeder dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
`ifdef FEEDER_STALL_EN
    .stall   (stall),
`endif
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_data  (a_data),
    .a_valid (a_valid),
    .b_data  (b_data),
    .b_valid (b_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int r, input int c,
                    input logic [31:0] v);
    wr_sel  = sel;
    wr_row  = 2'(r);
    wr_col  = 2'(c);
    wr_data = v;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
    if (!sel && r < N && c < K) ma[r][c] = v;
    if (sel && r < K && c < M) mb[r][c] = v;
  endtask

  // p = stream phase (cycle index since start, minus 1); -1 = idle
  task automatic check_phase(input int p);
    logic [N-1:0] eav;
    logic [M-1:0] ebv;
    logic [31:0]  ev;
    int d;
    eav = '0;
    ebv = '0;
    for (int i = 0; i < N; i++) begin
      d  = p - i;
      ev = '0;
      if (p >= 0 && p < T && d >= 0 && d < K) begin
        eav[i] = 1'b1;
        ev     = ma[i][d];
      end
      chk($sformatf("a%0d_p%0d", i, p), a_data[i*DW +: DW], ev);
    end
    for (int j = 0; j < M; j++) begin
      d  = p - j;
      ev = '0;
      if (p >= 0 && p < T && d >= 0 && d < K) begin
        ebv[j] = 1'b1;
        ev     = mb[d][j];
      end
      chk($sformatf("b%0d_p%0d", j, p), b_data[j*DW +: DW], ev);
    end
    chk($sformatf("a_valid_p%0d", p), 32'(a_valid), 32'(eav));
    chk($sformatf("b_valid_p%0d", p), 32'(b_valid), 32'(ebv));
    chk($sformatf("busy_p%0d", p), 32'(busy), 32'(p >= 0));
    chk($sformatf("done_p%0d", p), 32'(done), 32'(p == LAST));
  endtask

  task automatic run(input bit do_stall, input bit wr_same,
                     input bit noise);
    int p, c;
    bit stl;
    p = 0;
    c = 0;
    start = 1'b1;
    if (wr_same) begin
      wr_sel  = 1'($urandom_range(0, 1));
      wr_row  = 2'd0;
      wr_col  = 2'd0;
      wr_data = $urandom;
      wr_en   = 1'b1;
      if (wr_sel) mb[0][0] = wr_data;
      else        ma[0][0] = wr_data;
    end
    step();
    start = 1'b0;
    wr_en = 1'b0;
    while (p <= LAST && c < 100) begin
      check_phase(p);
      stl   = do_stall && STALL_EN && ($urandom_range(0, 3) == 0);
      stall = stl;
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        wr_en   = 1'($urandom_range(0, 1));
        wr_sel  = 1'($urandom_range(0, 1));
        wr_row  = 2'($urandom_range(0, 3));
        wr_col  = 2'($urandom_range(0, 3));
        wr_data = $urandom;
      end
      step();
      c++;
      if (!(stl && p < LAST)) p++;
    end
    stall = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    chk("run_bound", 32'(c < 100), 32'd1);
    check_phase(-1);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0; stall = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    step();
    step();
    check_phase(-1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        wr(1'b0, i, k, 32'(3*i + k + 1));
        wr(1'b1, i, k, 32'(i == k));
      end

    start = 1'b1;
    step();
    start = 1'b0;
    chk("c1_a_valid", 32'(a_valid), 32'b001);
    chk("c1_a0", a_data[31:0], 32'd1);
    chk("c1_b0", b_data[31:0], 32'd1);
    chk("c1_busy", 32'(busy), 32'd1);
    step();
    step();
    chk("c3_a_valid", 32'(a_valid), 32'b111);
    chk("c3_a0", a_data[31:0], 32'd3);
    chk("c3_a1", a_data[63:32], 32'd5);
    chk("c3_a2", a_data[95:64], 32'd7);
    chk("c3_b1", b_data[63:32], 32'd1);
    wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0;
    wr_data = 32'd99; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    chk("c5_a_valid", 32'(a_valid), 32'b100);
    chk("c5_a2", a_data[95:64], 32'd9);
    chk("c5_b2", b_data[95:64], 32'd1);
    step();
    chk("c6_a_valid", 32'(a_valid), 32'b000);
    for (int c = 7; c <= 11; c++) begin
      step();
      chk($sformatf("c%0d_done", c), 32'(done), 32'(c == 10));
      chk($sformatf("c%0d_busy", c), 32'(busy), 32'(c <= 10));
    end

    run(1'b0, 1'b0, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check_phase(-1);
    step();
    rst = 1'b0;
    step();
    run(1'b0, 1'b0, 1'b0);

`ifdef FEEDER_STALL_EN
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    chk("stall_c5_a_valid", 32'(a_valid), 32'b111);
    chk("stall_c5_a0", a_data[31:0], 32'd3);
    chk("stall_c5_a2", a_data[95:64], 32'd7);
    for (int c = 6; c <= 13; c++) begin
      step();
      chk($sformatf("stall_c%0d_done", c), 32'(done), 32'(c == 12));
    end
`endif

    wr(1'b0, 3, 1, 32'hdead);
    wr(1'b1, 1, 3, 32'hbeef);
    wr(1'b1, 3, 0, 32'hcafe);
    run(1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++) begin
          wr(1'b0, i, k, $urandom);
          wr(1'b1, i, k, $urandom);
        end
      run(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
